// File: rtl/pmic_smpl_ctrl_if.sv
// ----------------------------------------------------------------------------
// pmic_smpl_ctrl_if
//
// Purpose: the Wishbone (pipelined, classic single-beat) slave bundle of the
// mic sample controller. The signal names keep the bus direction prefix
// as seen from the controller, so the same names appear on both sides.
//
// Signals:
//   i_wb_cyc, i_wb_stb, i_wb_we  bus cycle / strobe / write-enable
//   i_wb_addr                    0 = CTRL register, 1 = DATA register
//   i_wb_data  [31:0]            write data
//   o_wb_ack                     acknowledge, one cycle after each access
//   o_wb_stall                   never stalls
//   o_wb_data  [31:0]            read data, valid with o_wb_ack
//
// Modports: slave (the controller), master (the interconnect / testbench).
// ----------------------------------------------------------------------------
interface pmic_smpl_ctrl_if;
    logic        i_wb_cyc;
    logic        i_wb_stb;
    logic        i_wb_we;
    logic        i_wb_addr;
    logic [31:0] i_wb_data;
    logic        o_wb_ack;
    logic        o_wb_stall;
    logic [31:0] o_wb_data;

    modport slave (
        input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
        output o_wb_ack, o_wb_stall, o_wb_data
    );

    modport master (
        output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
        input  o_wb_ack, o_wb_stall, o_wb_data
    );
endinterface

// File: rtl/pmic_smpl_ctrl.sv
// ----------------------------------------------------------------------------
// pmic_smpl_ctrl
//
// Purpose: Wishbone-controlled sequencer for one microphone sample FIFO.
// After enable it throws away the first SETTLE samples (the mic start-up
// transient), then forwards every sample strobe into the FIFO. A FIFO
// overflow halts capture until software resets the FIFO or disables the
// block. The bus sees a control/status register and a pop-on-read data
// register; a level interrupt reports half-full or halted.
//
// Parameters:
//   BW      sample width (1..30)
//   LGFLEN  log2 of the FIFO depth; informational, the fill level comes
//           from i_fifo_status
//   SETTLE  samples discarded after enable (0 = none)
//
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   wb                 Wishbone slave (see pmic_smpl_ctrl_if)
//   i_smpl_stb/i_smpl  one-cycle sample strobe and sample value
//   o_fifo_rst         FIFO reset pulse (also high the cycle after i_rst)
//   o_fifo_wr/o_fifo_data  FIFO write port, one cycle after the strobe
//   o_fifo_rd          FIFO pop, combinational with the DATA read access
//   i_fifo_empty_n, i_fifo_data  FIFO head (first-word fall-through)
//   i_fifo_status      {fill[13:0], half_full, empty_n}
//   i_fifo_err         FIFO overflow, sticky until FIFO reset
//   o_int              level interrupt
// ----------------------------------------------------------------------------
module pmic_smpl_ctrl #(
    parameter int BW     = 12,
    parameter int LGFLEN = 9,
    parameter int SETTLE = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    pmic_smpl_ctrl_if.slave  wb,
    input  logic             i_smpl_stb,
    input  logic [BW-1:0]    i_smpl,
    output logic             o_fifo_rst,
    output logic             o_fifo_wr,
    output logic [BW-1:0]    o_fifo_data,
    output logic             o_fifo_rd,
    input  logic             i_fifo_empty_n,
    input  logic [BW-1:0]    i_fifo_data,
    input  logic [15:0]      i_fifo_status,
    input  logic             i_fifo_err,
    output logic             o_int
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETTLE = 2'b01,
        ST_RUN    = 2'b10,
        ST_HALTED = 2'b11
    } state_t;

    localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE);
    // With no settle period a (re)start goes straight to capturing.
    localparam state_t START_STATE = (SETTLE == 0) ? ST_RUN : ST_SETTLE;

    state_t      state, state_d;
    logic [15:0] settle_cnt, settle_cnt_d;
    logic        enable;
    logic        inten;

    logic        bus_access;
    logic        ctrl_wr;
    logic        data_rd;
    logic        fifo_rst_req;
    logic [31:0] ctrl_rd_word;
    logic [31:0] data_rd_word;

    assign bus_access   = wb.i_wb_stb && wb.i_wb_cyc;
    assign ctrl_wr      = bus_access && wb.i_wb_we && !wb.i_wb_addr;
    assign data_rd      = bus_access && !wb.i_wb_we && wb.i_wb_addr;
    assign fifo_rst_req = ctrl_wr && wb.i_wb_data[31];

    assign wb.o_wb_stall = 1'b0;

    // Pop in the access cycle so the FIFO presents the next head one cycle
    // later; a read coinciding with reset must not consume a sample.
    assign o_fifo_rd = data_rd && i_fifo_empty_n && !i_rst;

    assign ctrl_rd_word = {state, i_fifo_err, o_int, inten, enable, 10'd0, i_fifo_status};

    // The sample field reads as zero when the FIFO is empty, so the stale
    // head contents never leak onto the bus.
    always_comb begin
        data_rd_word     = '0;
        data_rd_word[31] = i_fifo_empty_n;
        if (i_fifo_empty_n) begin
            data_rd_word[BW-1:0] = i_fifo_data;
        end
    end

    // Next-state logic. Disable wins over everything; a FIFO reset restarts
    // the settle period, because the freshly reset FIFO must again start
    // with clean samples.
    always_comb begin
        state_d      = state;
        settle_cnt_d = settle_cnt;
        if (!enable) begin
            state_d = ST_IDLE;
        end else if (o_fifo_rst || state == ST_IDLE) begin
            state_d      = START_STATE;
            settle_cnt_d = SETTLE_LOAD;
        end else begin
            case (state)
                ST_SETTLE: begin
                    if (i_smpl_stb) begin
                        settle_cnt_d = settle_cnt - 16'd1;
                        if (settle_cnt == 16'd1) begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (i_fifo_err) begin
                        state_d = ST_HALTED;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
        end else begin
            state      <= state_d;
            settle_cnt <= settle_cnt_d;
        end
    end

    // The FIFO reset output comes up high right after i_rst so the FIFO and
    // this controller leave reset together.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            enable     <= 1'b0;
            inten      <= 1'b0;
            o_fifo_rst <= 1'b1;
        end else begin
            o_fifo_rst <= fifo_rst_req;
            if (ctrl_wr) begin
                enable <= wb.i_wb_data[26];
                inten  <= wb.i_wb_data[27];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wb.o_wb_ack  <= 1'b0;
            wb.o_wb_data <= '0;
        end else begin
            wb.o_wb_ack <= bus_access;
            if (bus_access && !wb.i_wb_we) begin
                wb.o_wb_data <= wb.i_wb_addr ? data_rd_word : ctrl_rd_word;
            end
        end
    end

    // A write is suppressed when it would land in the FIFO reset cycle, and
    // also right after it, since that sample predates the restarted settle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_fifo_wr   <= 1'b0;
            o_fifo_data <= '0;
        end else begin
            o_fifo_wr   <= i_smpl_stb && (state == ST_RUN) && !fifo_rst_req && !o_fifo_rst;
            o_fifo_data <= i_smpl;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_int <= 1'b0;
        end else begin
            o_int <= inten && enable && (i_fifo_status[1] || state == ST_HALTED);
        end
    end

    // Write-data bits with no register behind them, and the documentation
    // parameter, are collected here so they are visibly intentional.
    logic unused_bits;
    assign unused_bits = &{1'b0, wb.i_wb_data[30:28], wb.i_wb_data[25:0], LGFLEN[0]};

endmodule

// File: tb/tb_pmic_smpl_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pmic_smpl_ctrl
//
// Purpose: directed testbench for pmic_smpl_ctrl. A behavioural FIFO
// (queue-based, 512 deep) answers the controller's FIFO port. Inputs are
// driven 1 time unit after the rising edge, outputs observed on the
// falling edge.
// ----------------------------------------------------------------------------
module tb_pmic_smpl_ctrl;

    localparam int BW     = 12;
    localparam int LGFLEN = 9;
    localparam int SETTLE = 16;
    localparam int DEPTH  = 1 << LGFLEN;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          smpl_stb = 1'b0;
    logic [BW-1:0] smpl = '0;
    logic          fifo_rst;
    logic          fifo_wr;
    logic [BW-1:0] fifo_wdata;
    logic          fifo_rd;
    logic          fifo_empty_n = 1'b0;
    logic [BW-1:0] fifo_head = '0;
    logic [15:0]   fifo_status = '0;
    logic          fifo_err = 1'b0;
    logic          irq;

    int checks = 0;
    int fails  = 0;

    pmic_smpl_ctrl_if wb ();

    pmic_smpl_ctrl #(
        .BW     (BW),
        .LGFLEN (LGFLEN),
        .SETTLE (SETTLE)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .wb             (wb),
        .i_smpl_stb     (smpl_stb),
        .i_smpl         (smpl),
        .o_fifo_rst     (fifo_rst),
        .o_fifo_wr      (fifo_wr),
        .o_fifo_data    (fifo_wdata),
        .o_fifo_rd      (fifo_rd),
        .i_fifo_empty_n (fifo_empty_n),
        .i_fifo_data    (fifo_head),
        .i_fifo_status  (fifo_status),
        .i_fifo_err     (fifo_err),
        .o_int          (irq)
    );

    always #5 clk = ~clk;

    // Behavioural first-word-fall-through FIFO with sticky overflow flag.
    logic [BW-1:0] fifo_q[$];
    always @(posedge clk) begin
        if (fifo_rst === 1'b1) begin
            fifo_q.delete();
            fifo_err <= 1'b0;
        end else begin
            if (fifo_rd === 1'b1 && fifo_q.size() > 0) begin
                void'(fifo_q.pop_front());
            end
            if (fifo_wr === 1'b1) begin
                if (fifo_q.size() < DEPTH) begin
                    fifo_q.push_back(fifo_wdata);
                end else begin
                    fifo_err <= 1'b1;
                end
            end
        end
        fifo_empty_n <= (fifo_q.size() != 0);
        fifo_head    <= (fifo_q.size() != 0) ? fifo_q[0] : '0;
        fifo_status  <= {14'(fifo_q.size()), (fifo_q.size() >= DEPTH / 2), (fifo_q.size() != 0)};
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic bus_idle();
        wb.i_wb_cyc  = 1'b0;
        wb.i_wb_stb  = 1'b0;
        wb.i_wb_we   = 1'b0;
        wb.i_wb_addr = 1'b0;
        wb.i_wb_data = '0;
    endtask

    task automatic wb_write(input logic addr, input logic [31:0] data,
                            output logic ack_seen, output logic rst_seen);
        @(posedge clk); #1;
        wb.i_wb_cyc  = 1'b1;
        wb.i_wb_stb  = 1'b1;
        wb.i_wb_we   = 1'b1;
        wb.i_wb_addr = addr;
        wb.i_wb_data = data;
        @(posedge clk); #1;
        bus_idle();
        #4;
        ack_seen = wb.o_wb_ack;
        rst_seen = fifo_rst;
    endtask

    task automatic wb_read(input logic addr, output logic rd_seen,
                           output logic ack_seen, output logic [31:0] data_seen);
        @(posedge clk); #1;
        wb.i_wb_cyc  = 1'b1;
        wb.i_wb_stb  = 1'b1;
        wb.i_wb_we   = 1'b0;
        wb.i_wb_addr = addr;
        #4;
        rd_seen = fifo_rd;
        @(posedge clk); #1;
        bus_idle();
        #4;
        ack_seen  = wb.o_wb_ack;
        data_seen = wb.o_wb_data;
    endtask

    task automatic test_reset();
        logic rd, ack;
        logic [31:0] d;
        rst = 1'b1;
        bus_idle();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #4;
        checks++; if (fifo_rst !== 1'b1) begin fails++; $display("[TB] FAIL reset_fifo_rst_pulse: got %0b expected 1", fifo_rst); end
        checks++; if (wb.o_wb_ack !== 1'b0) begin fails++; $display("[TB] FAIL reset_ack: got %0b expected 0", wb.o_wb_ack); end
        checks++; if (fifo_wr !== 1'b0 || irq !== 1'b0) begin fails++; $display("[TB] FAIL reset_wr_int: got wr=%0b int=%0b expected 0 0", fifo_wr, irq); end
        @(posedge clk); #5;
        checks++; if (fifo_rst !== 1'b0) begin fails++; $display("[TB] FAIL reset_fifo_rst_clear: got %0b expected 0", fifo_rst); end
        wb_read(1'b0, rd, ack, d);
        checks++; if (ack !== 1'b1) begin fails++; $display("[TB] FAIL reset_ctrl_ack: got %0b expected 1", ack); end
        checks++; if (d !== 32'h0000_0000) begin fails++; $display("[TB] FAIL reset_ctrl_read: got %08h expected 00000000", d); end
    endtask

    task automatic test_settle_run();
        logic rd, ack, r, exp_wr;
        logic [31:0] d;
        wb_write(1'b0, 32'h0400_0000, ack, r);
        checks++; if (ack !== 1'b1) begin fails++; $display("[TB] FAIL enable_write_ack: got %0b expected 1", ack); end
        wb_read(1'b0, rd, ack, d);
        checks++; if (d !== 32'h4400_0000) begin fails++; $display("[TB] FAIL settle_ctrl_read: got %08h expected 44000000", d); end
        for (int k = 0; k <= 20; k++) begin
            @(posedge clk); #1;
            smpl_stb = (k < 20);
            smpl     = BW'(k);
            #4;
            exp_wr = (k >= 17);
            checks++; if (fifo_wr !== exp_wr) begin fails++; $display("[TB] FAIL settle_wr_cycle%0d: got %0b expected %0b", k, fifo_wr, exp_wr); end
            if (exp_wr) begin
                checks++; if (fifo_wdata !== BW'(k - 1)) begin fails++; $display("[TB] FAIL settle_wdata_cycle%0d: got %0h expected %0h", k, fifo_wdata, k - 1); end
            end
        end
        smpl_stb = 1'b0;
        wb_read(1'b0, rd, ack, d);
        checks++; if (d !== 32'h8400_0011) begin fails++; $display("[TB] FAIL run_ctrl_read: got %08h expected 84000011", d); end
    endtask

    task automatic test_data_reads();
        logic [31:0] exp_data [5];
        int rd_count;
        exp_data = '{32'h8000_0010, 32'h8000_0011, 32'h8000_0012, 32'h8000_0013, 32'h0000_0000};
        rd_count = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            wb.i_wb_cyc  = 1'b1;
            wb.i_wb_stb  = 1'b1;
            wb.i_wb_we   = 1'b0;
            wb.i_wb_addr = 1'b1;
            #4;
            if (fifo_rd === 1'b1) rd_count++;
            checks++; if (fifo_rd !== (i < 4)) begin fails++; $display("[TB] FAIL data_pop%0d: got %0b expected %0b", i, fifo_rd, (i < 4)); end
            if (i > 0) begin
                checks++; if (wb.o_wb_ack !== 1'b1 || wb.o_wb_data !== exp_data[i-1]) begin fails++; $display("[TB] FAIL data_read%0d: got ack=%0b data=%08h expected ack=1 data=%08h", i - 1, wb.o_wb_ack, wb.o_wb_data, exp_data[i-1]); end
            end
        end
        @(posedge clk); #1;
        bus_idle();
        #4;
        checks++; if (wb.o_wb_ack !== 1'b1 || wb.o_wb_data !== exp_data[4]) begin fails++; $display("[TB] FAIL data_read4: got ack=%0b data=%08h expected ack=1 data=%08h", wb.o_wb_ack, wb.o_wb_data, exp_data[4]); end
        @(posedge clk); #5;
        checks++; if (wb.o_wb_ack !== 1'b0) begin fails++; $display("[TB] FAIL data_no_extra_ack: got %0b expected 0", wb.o_wb_ack); end
        checks++; if (rd_count != 4) begin fails++; $display("[TB] FAIL data_pop_count: got %0d expected 4", rd_count); end
    endtask

    task automatic test_overflow();
        logic rd, ack, r;
        logic [31:0] d;
        for (int j = 0; j < DEPTH + 1; j++) begin
            @(posedge clk); #1;
            smpl_stb = 1'b1;
            smpl     = BW'(j);
        end
        @(posedge clk); #1;
        smpl_stb = 1'b0;
        repeat (4) @(posedge clk);
        wb_read(1'b0, rd, ack, d);
        checks++; if (d !== 32'hE400_0803) begin fails++; $display("[TB] FAIL halted_ctrl_read: got %08h expected e4000803", d); end
        for (int k = 0; k <= 5; k++) begin
            @(posedge clk); #1;
            smpl_stb = (k < 5);
            smpl     = BW'(k + 7);
            #4;
            checks++; if (fifo_wr !== 1'b0) begin fails++; $display("[TB] FAIL halted_no_wr%0d: got %0b expected 0", k, fifo_wr); end
        end
        smpl_stb = 1'b0;
        wb_write(1'b0, 32'h8C00_0000, ack, r);
        checks++; if (ack !== 1'b1 || r !== 1'b1) begin fails++; $display("[TB] FAIL restart_write: got ack=%0b fifo_rst=%0b expected 1 1", ack, r); end
        @(posedge clk); #5;
        checks++; if (fifo_rst !== 1'b0) begin fails++; $display("[TB] FAIL restart_rst_self_clear: got %0b expected 0", fifo_rst); end
        repeat (2) @(posedge clk);
        wb_read(1'b0, rd, ack, d);
        checks++; if (d !== 32'h4C00_0000) begin fails++; $display("[TB] FAIL restart_settle_read: got %08h expected 4c000000", d); end
        for (int k = 0; k <= 16; k++) begin
            @(posedge clk); #1;
            smpl_stb = (k < 16);
            smpl     = BW'(k + 40);
            #4;
            checks++; if (fifo_wr !== 1'b0) begin fails++; $display("[TB] FAIL restart_settle_no_wr%0d: got %0b expected 0", k, fifo_wr); end
        end
        smpl_stb = 1'b0;
        wb_read(1'b0, rd, ack, d);
        checks++; if (d !== 32'h8C00_0000) begin fails++; $display("[TB] FAIL restart_run_read: got %08h expected 8c000000", d); end
    endtask

    task automatic test_half_full_irq();
        logic rd, ack, r;
        logic [31:0] d;
        for (int k = 0; k <= 258; k++) begin
            @(posedge clk); #1;
            smpl_stb = (k < 256);
            smpl     = BW'(k + 100);
            #4;
            if (k == 257) begin
                checks++; if (irq !== 1'b0) begin fails++; $display("[TB] FAIL irq_before_lag: got %0b expected 0", irq); end
            end
            if (k == 258) begin
                checks++; if (irq !== 1'b1) begin fails++; $display("[TB] FAIL irq_half_full: got %0b expected 1", irq); end
            end
        end
        smpl_stb = 1'b0;
        wb_read(1'b0, rd, ack, d);
        checks++; if (d !== 32'h9C00_0403) begin fails++; $display("[TB] FAIL irq_ctrl_read: got %08h expected 9c000403", d); end
        wb_write(1'b0, 32'h0800_0000, ack, r);
        @(posedge clk); #5;
        checks++; if (irq !== 1'b0) begin fails++; $display("[TB] FAIL irq_after_disable: got %0b expected 0", irq); end
        wb_read(1'b0, rd, ack, d);
        checks++; if (d !== 32'h0800_0403) begin fails++; $display("[TB] FAIL disable_ctrl_read: got %08h expected 08000403", d); end
    endtask

    task automatic test_reset_mid_read();
        logic rd, ack;
        logic [31:0] d;
        @(posedge clk); #1;
        rst          = 1'b1;
        wb.i_wb_cyc  = 1'b1;
        wb.i_wb_stb  = 1'b1;
        wb.i_wb_we   = 1'b0;
        wb.i_wb_addr = 1'b1;
        #4;
        checks++; if (fifo_rd !== 1'b0) begin fails++; $display("[TB] FAIL rst_read_no_pop: got %0b expected 0", fifo_rd); end
        @(posedge clk); #1;
        rst = 1'b0;
        bus_idle();
        #4;
        checks++; if (wb.o_wb_ack !== 1'b0) begin fails++; $display("[TB] FAIL rst_read_no_ack: got %0b expected 0", wb.o_wb_ack); end
        checks++; if (fifo_rst !== 1'b1 || wb.o_wb_data !== 32'h0 || fifo_wr !== 1'b0 || irq !== 1'b0) begin fails++; $display("[TB] FAIL rst_read_outputs: got rst=%0b data=%08h wr=%0b int=%0b expected 1 00000000 0 0", fifo_rst, wb.o_wb_data, fifo_wr, irq); end
        wb_read(1'b0, rd, ack, d);
        checks++; if (d !== 32'h0000_0000) begin fails++; $display("[TB] FAIL rst_read_ctrl: got %08h expected 00000000", d); end
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        wb.i_wb_cyc  = 1'b1;
        wb.i_wb_stb  = 1'b1;
        wb.i_wb_we   = 1'b1;
        wb.i_wb_addr = 1'b1;
        wb.i_wb_data = 32'hFFFF_FFFF;
        #4;
        checks++; if (wb.o_wb_stall !== 1'b0) begin fails++; $display("[TB] FAIL b2b_stall: got %0b expected 0", wb.o_wb_stall); end
        @(posedge clk); #1;
        wb.i_wb_we   = 1'b0;
        wb.i_wb_addr = 1'b0;
        #4;
        checks++; if (wb.o_wb_ack !== 1'b1) begin fails++; $display("[TB] FAIL b2b_ack_first: got %0b expected 1", wb.o_wb_ack); end
        @(posedge clk); #1;
        bus_idle();
        #4;
        checks++; if (wb.o_wb_ack !== 1'b1 || wb.o_wb_data !== 32'h0000_0000) begin fails++; $display("[TB] FAIL b2b_ack_second: got ack=%0b data=%08h expected ack=1 data=00000000", wb.o_wb_ack, wb.o_wb_data); end
    endtask

    initial begin
        $display("[TB] starting pmic_smpl_ctrl test");
        test_reset();
        test_settle_run();
        test_data_reads();
        test_overflow();
        test_half_full_irq();
        test_reset_mid_read();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/pmic_smpl_ctrl.md
Name: pmic_smpl_ctrl

Overview:
- Wishbone-controlled sequencer for one sample FIFO (BW-bit samples, 2^LGFLEN deep, one-cycle-latency read port, first-word-fallthrough head).
- Gates microphone sample strobes into the FIFO and discards start-up samples after enable.
- Halts capture on FIFO overflow, gives the bus a control/status register and a pop-on-read data register, and drives an interrupt.
- Sits between the bus interconnect and the FIFO instance in the mic capture path.

Parameters:
- BW, 12, sample width (1..30).
- LGFLEN, 9, log2 FIFO depth; documentation only, fill taken from i_fifo_status.
- SETTLE, 16, samples discarded after enable (0..65535; 0 = none).

Ports:
- i_clk  in  1  single clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_wb_cyc, i_wb_stb, i_wb_we  in  1  Wishbone pipelined slave.
- i_wb_addr  in  1  0 = CTRL, 1 = DATA.
- i_wb_data  in  32  write data.
- o_wb_ack  out  1  ack.
- o_wb_stall  out  1  tied 0.
- o_wb_data  out  32  read data.
- i_smpl_stb  in  1  one-cycle strobe: new sample valid.
- i_smpl  in  BW  sample value.
- o_fifo_rst  out  1  FIFO reset pulse.
- o_fifo_wr  out  1  FIFO write.
- o_fifo_data  out  BW  FIFO write data.
- o_fifo_rd  out  1  FIFO pop.
- i_fifo_empty_n  in  1  FIFO non-empty.
- i_fifo_data  in  BW  FIFO head.
- i_fifo_status  in  16  {fill[13:0], half_full, empty_n}.
- i_fifo_err  in  1  FIFO overflow sticky.
- o_int  out  1  level interrupt.

Behaviour:
- Reset values (i_rst sampled high at an edge): state IDLE, enable 0, inten 0, settle count 0, o_wb_ack 0, o_wb_data 0, o_fifo_wr 0, o_fifo_data 0, o_int 0. o_fifo_rst is 1 during the cycle after reset, so FIFO and controller reset together.
- Bus access = i_wb_stb && i_wb_cyc. o_wb_ack is 1 exactly one cycle after each access, writes included; back-to-back accesses are acked back-to-back.
- CTRL write:
  - bit26 → enable; bit27 → inten.
  - bit31 = 1 → o_fifo_rst high for the next cycle only (self-clearing).
- CTRL read:
  - [31:30] state (00 IDLE, 01 SETTLE, 10 RUN, 11 HALTED), [29] i_fifo_err, [28] o_int, [27] inten, [26] enable, [25:16] 0, [15:0] i_fifo_status.
  - All fields are sampled in the access cycle.
- DATA read:
  - [31] = i_fifo_empty_n, [BW-1:0] = i_fifo_data, all other bits 0. When empty, [BW-1:0] reads 0.
  - o_fifo_rd = access && !we && addr==1 && i_fifo_empty_n, combinational, same cycle. The FIFO updates its head for the next cycle, so consecutive DATA reads return consecutive samples.
  - DATA writes are acked and ignored.
- State machine (evaluated each cycle, priority top-down):
  1. enable==0 → IDLE.
  2. FIFO reset cycle (o_fifo_rst high) → SETTLE, with count loaded to SETTLE (RUN directly if SETTLE==0).
  3. IDLE && enable → SETTLE, same load rule.
  4. SETTLE: each i_smpl_stb decrements count and the sample is discarded. A strobe with count==1 → RUN.
  5. RUN: i_fifo_err==1 → HALTED.
  6. HALTED: stays until a FIFO reset or disable.
- Capture path:
  - o_fifo_wr <= i_smpl_stb && state==RUN; o_fifo_data <= i_smpl. One-cycle latency from strobe to write.
  - A strobe in the cycle the state enters RUN is not written. The strobe that ends SETTLE is discarded.
  - No writes in IDLE, SETTLE or HALTED, and none in the cycle o_fifo_rst is high.
- Simultaneous cases:
  - CTRL write with bit26=0 and bit31=1 → FIFO reset issued, next state IDLE.
  - Enable written 1 while already running → no effect.
  - Pop and FIFO write in the same cycle are both issued; the FIFO handles that case.
- o_int <= inten && enable && (i_fifo_status[1] || state==HALTED). Registered, one-cycle lag.
- Reset mid-transaction: a pending ack is dropped and no pop is issued during reset.

Test Plan:
1. Reset, then read CTRL → 0x0000_0000 with [15:0]=i_fifo_status (model: 0x0000); o_fifo_rst seen 1 cycle after reset.
2. Write CTRL=0x0400_0000 (enable), SETTLE=16, issue 20 strobes with samples 0..19 → exactly samples 16..19 written, states 01 then 10, each o_fifo_wr 1 cycle after its strobe.
3. After 4 writes, 5 back-to-back DATA reads → 0x8000_0010, 0x8000_0011, 0x8000_0012, 0x8000_0013, then 0x0000_0000; o_fifo_rd high 4 cycles only.
4. Run with no reads until i_fifo_err=1 → state 11, o_fifo_wr stays 0. Write CTRL=0x8C00_0000 → one o_fifo_rst pulse, state 01, then 10 after 16 more strobes.
5. inten=1, fill to half depth (256 for LGFLEN=9) → o_int rises 1 cycle after half_full. Write CTRL=0x0800_0000 (disable) → state 00, o_int 0 next cycle.
6. Assert i_rst in the cycle of a DATA read → no ack and no o_fifo_rd; all registers back to reset values.
